jt6295_cmdgen: RTL and testbench

//  Host-side command writer for the JT6295 CPU write port. Accepts queued

---
 rtl/jt6295_cmdgen_pkg.sv | 42 ++++
 rtl/jt6295_cmdgen_if.sv | 22 ++
 rtl/jt6295_cmdgen_cmdfifo.sv | 59 +++++
 rtl/jt6295_cmdgen.sv | 131 +++++++++++++
 tb/tb_jt6295_cmdgen.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jt6295_cmdgen_pkg.sv
// Shared types and command encoding for the JT6295 host-side command writer.
// Start command is two bytes ({1,phrase} then {ch,att}); stop is one byte ({0,ch,000}).
package jt6295_cmdgen_pkg;

  localparam int unsigned PhraseW        = 7;
  localparam int unsigned MaskW          = 4;
  localparam int unsigned AttW           = 4;
  localparam int unsigned CmdStartBit    = 7;
  localparam int unsigned StopMaskOffset = 3;

  typedef struct packed {
    logic               stop;
    logic [PhraseW-1:0] phrase;
    logic [MaskW-1:0]   ch;
    logic [AttW-1:0]    att;
  } cmd_req_t;

  typedef enum logic [2:0] {
    StIdle,
    StB1Lo,
    StB1Hi,
    StB2Lo,
    StB2Hi
  } cmd_state_e;

  function automatic logic [7:0] first_byte(cmd_req_t r);
    logic [7:0] b;
    b = '0;
    if (r.stop) begin
      b[StopMaskOffset +: MaskW] = r.ch;
    end else begin
      b[CmdStartBit]    = 1'b1;
      b[PhraseW-1:0]    = r.phrase;
    end
    return b;
  endfunction

  function automatic logic [7:0] second_byte(cmd_req_t r);
    return {r.ch, r.att};
  endfunction

endpackage

// File: rtl/jt6295_cmdgen_if.sv
// Request channel from sequencer/soft-CPU into the command writer.
// Host drives the request fields with valid; the writer answers with ready.
interface jt6295_cmdgen_if;

  logic                                     req_valid;
  logic                                     req_ready;
  logic                                     req_stop;
  logic [jt6295_cmdgen_pkg::PhraseW-1:0]    req_phrase;
  logic [jt6295_cmdgen_pkg::MaskW-1:0]      req_ch;
  logic [jt6295_cmdgen_pkg::AttW-1:0]       req_att;

  modport master (
    output req_valid, req_stop, req_phrase, req_ch, req_att,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_stop, req_phrase, req_ch, req_att,
    output req_ready
  );

endinterface

// File: rtl/jt6295_cmdgen_cmdfifo.sv
// Request FIFO for the command writer; pointers carry one extra bit so full and
// empty are distinguishable. Flush clears occupancy and drops a same-cycle push.
module jt6295_cmdgen_cmdfifo
  import jt6295_cmdgen_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  cmd_req_t               data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output cmd_req_t               data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne  = (PtrW + 1)'(1);
  localparam logic [PtrW:0] LvlFull = (PtrW + 1)'(Depth);

  logic [PtrW:0] wptr_q, wptr_d;
  logic [PtrW:0] rptr_q, rptr_d;
  cmd_req_t      mem_q [Depth];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + PtrOne;
      if (pop_i)  rptr_d = rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wptr_q[PtrW-1:0]] <= data_i;
  end

  assign level_o = wptr_q - rptr_q;
  assign full_o  = (level_o == LvlFull);
  assign empty_o = (level_o == '0);
  assign data_o  = mem_q[rptr_q[PtrW-1:0]];

endmodule

// File: rtl/jt6295_cmdgen.sv
// Serialises queued start/stop requests into wrn/dout byte cycles for the JT6295
// CPU port: wrn low LowCyc cycles, then high GapCyc cycles, per byte.
module jt6295_cmdgen
  import jt6295_cmdgen_pkg::*;
#(
  parameter int unsigned Depth  = 4,
  parameter int unsigned LowCyc = 4,
  parameter int unsigned GapCyc = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  jt6295_cmdgen_if.slave         req_if,
  input  logic                   flush_i,
  output logic                   wrn_o,
  output logic [7:0]             dout_o,
  output logic                   idle_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned TMax   = (LowCyc > GapCyc) ? LowCyc : GapCyc;
  localparam int unsigned TimerW = $clog2(TMax);
  localparam logic [TimerW-1:0] LowLoad  = TimerW'(LowCyc - 1);
  localparam logic [TimerW-1:0] GapLoad  = TimerW'(GapCyc - 1);
  localparam logic [TimerW-1:0] PreLoad  = TimerW'(GapCyc - 2);
  localparam logic [TimerW-1:0] TimerOne = TimerW'(1);

  cmd_state_e        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              wrn_q, wrn_d;
  logic [7:0]        dout_q, dout_d;
  cmd_req_t          cur_q, cur_d;

  cmd_req_t push_req, head_req;
  logic     fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign push_req = '{stop:   req_if.req_stop,
                      phrase: req_if.req_phrase,
                      ch:     req_if.req_ch,
                      att:    req_if.req_att};

  assign req_if.req_ready = !fifo_full;
  assign fifo_push        = req_if.req_valid && !fifo_full && !flush_i;

  jt6295_cmdgen_cmdfifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (push_req),
    .pop_i   (fifo_pop),
    .flush_i (flush_i),
    .data_o  (head_req),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    wrn_d    = wrn_q;
    dout_d   = dout_q;
    cur_d    = cur_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A flush in the same cycle drops the head instead of launching it.
        if (!fifo_empty && !flush_i) begin
          fifo_pop = 1'b1;
          cur_d    = head_req;
          dout_d   = first_byte(head_req);
          wrn_d    = 1'b0;
          timer_d  = LowLoad;
          state_d  = StB1Lo;
        end
      end
      StB1Lo, StB2Lo: begin
        if (timer_q == '0) begin
          wrn_d   = 1'b1;
          timer_d = GapLoad;
          state_d = (state_q == StB1Lo) ? StB1Hi : StB2Hi;
        end else begin
          timer_d = timer_q - TimerOne;
        end
      end
      StB1Hi: begin
        if (timer_q == '0) begin
          if (cur_q.stop) begin
            state_d = StIdle;
          end else begin
            dout_d  = second_byte(cur_q);
            wrn_d   = 1'b0;
            timer_d = LowLoad;
            state_d = StB2Lo;
          end
        end else begin
          timer_d = timer_q - TimerOne;
          // Present byte2 early so dout is settled well before wrn falls again.
          if (timer_q == PreLoad && !cur_q.stop) dout_d = second_byte(cur_q);
        end
      end
      StB2Hi: begin
        if (timer_q == '0) state_d = StIdle;
        else               timer_d = timer_q - TimerOne;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      wrn_q   <= 1'b1;
      dout_q  <= 8'h00;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      wrn_q   <= wrn_d;
      dout_q  <= dout_d;
      cur_q   <= cur_d;
    end
  end

  assign wrn_o  = wrn_q;
  assign dout_o = dout_q;
  assign idle_o = fifo_empty && (state_q == StIdle);

endmodule

// File: tb/tb_jt6295_cmdgen.sv
// Bench for jt6295_cmdgen: a request queue plus a byte-timeline model predict
// every wrn/dout cycle, level, ready and idle; a core model logs latched bytes.
module tb_jt6295_cmdgen;

  localparam int unsigned Depth  = 4;
  localparam int unsigned LowCyc = 4;
  localparam int unsigned GapCyc = 16;
  localparam int unsigned Per    = LowCyc + GapCyc;

  typedef struct {
    bit       stop;
    bit [6:0] ph;
    bit [3:0] ch;
    bit [3:0] att;
  } tb_req_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       wrn;
  logic [7:0] dout;
  logic       idle;
  logic [2:0] level;

  jt6295_cmdgen_if req_if ();

  jt6295_cmdgen #(
    .Depth  (Depth),
    .LowCyc (LowCyc),
    .GapCyc (GapCyc)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_if  (req_if),
    .flush_i (flush),
    .wrn_o   (wrn),
    .dout_o  (dout),
    .idle_o  (idle),
    .level_o (level)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  tb_req_t     pending[$];
  logic [7:0]  core_log[$];
  int          prev_size = 0;
  bit          flush_s   = 1'b0;
  bit          active    = 1'b0;
  bit          saw_full  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void encode(input tb_req_t r, output logic [7:0] b0,
                                 output logic [7:0] b1, output int n);
    if (r.stop) begin
      b0 = {1'b0, r.ch, 3'b000};
      b1 = b0;
      n  = 1;
    end else begin
      b0 = {1'b1, r.ph};
      b1 = {r.ch, r.att};
      n  = 2;
    end
  endfunction

  // Request-queue model: acceptance decided from model occupancy, flush wins.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        pending.delete();
        prev_size = 0;
        flush_s   = 1'b0;
      end else begin
        prev_size = pending.size();
        flush_s   = flush;
        if (flush) begin
          pending.delete();
        end else if (req_if.req_valid && pending.size() < Depth) begin
          pending.push_back('{stop: req_if.req_stop, ph: req_if.req_phrase,
                              ch: req_if.req_ch, att: req_if.req_att});
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each launch and checks the byte timeline.
  initial begin
    logic [7:0]  bytes [2];
    logic [7:0]  last_dout;
    int          nb;
    int unsigned launch_cyc;
    int unsigned t;
    tb_req_t     r;
    nb         = 0;
    launch_cyc = 0;
    last_dout  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active    = 1'b0;
        last_dout = 8'h00;
        continue;
      end
      if (active) begin
        t = cyc - launch_cyc;
        if (t == nb * Per) begin
          check("wrn_end", wrn, 1);
          active = 1'b0;
        end else begin
          check("wrn_phase", wrn, ((t % Per) < LowCyc) ? 0 : 1);
          if ((t % Per) <= LowCyc) check("dout_stable", dout, bytes[t / Per]);
          if ((t % Per) == LowCyc) core_log.push_back(dout);
        end
      end else if (prev_size > 0 && !flush_s) begin
        if (pending.size() == 0) begin
          check("launch_src", 0, 1);
        end else begin
          r = pending.pop_front();
          encode(r, bytes[0], bytes[1], nb);
          last_dout  = bytes[nb-1];
          launch_cyc = cyc;
          active     = 1'b1;
          check("launch_wrn", wrn, 0);
          check("launch_dout", dout, bytes[0]);
        end
      end else begin
        check("idle_wrn", wrn, 1);
        check("idle_dout", dout, last_dout);
      end
      if (!req_if.req_ready) saw_full = 1'b1;
      check("level", level, pending.size());
      check("ready", req_if.req_ready, (pending.size() < Depth) ? 1 : 0);
      check("idle", idle, (!active && pending.size() == 0) ? 1 : 0);
    end
  end

  task automatic drive(input bit v, input bit stop, input bit [6:0] ph, input bit [3:0] ch,
                       input bit [3:0] att);
    req_if.req_valid  = v;
    req_if.req_stop   = stop;
    req_if.req_phrase = ph;
    req_if.req_ch     = ch;
    req_if.req_att    = att;
  endtask

  task automatic send(input bit stop, input bit [6:0] ph, input bit [3:0] ch,
                      input bit [3:0] att);
    drive(1'b1, stop, ph, ch, att);
    for (int i = 0; i < 300; i++) begin
      if (req_if.req_ready) break;
      @(negedge clk);
    end
    if (!req_if.req_ready) check("send_timeout", 0, 1);
    @(negedge clk);
    drive(1'b0, 1'b0, 7'h0, 4'h0, 4'h0);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (idle && !active && pending.size() == 0) return;
      @(negedge clk);
    end
    check("idle_timeout", 0, 1);
  endtask

  initial begin
    int base;
    drive(1'b0, 1'b0, 7'h0, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    check("rst_wrn", wrn, 1);
    check("rst_dout", dout, 8'h00);
    check("rst_ready", req_if.req_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_level", level, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: start command
    base = core_log.size();
    send(1'b0, 7'h12, 4'b0100, 4'h3);
    wait_idle(400);
    check("t1_count", core_log.size() - base, 2);
    check("t1_b1", core_log[base], 8'h92);
    check("t1_b2", core_log[base+1], 8'h43);

    // T2: stop command
    base = core_log.size();
    send(1'b1, 7'h00, 4'b1010, 4'h0);
    wait_idle(400);
    check("t2_count", core_log.size() - base, 1);
    check("t2_b", core_log[base], 8'h50);

    // T3: overfill while the first command is in flight
    base     = core_log.size();
    saw_full = 1'b0;
    send(1'b0, 7'h2a, 4'b0011, 4'h7);
    for (int i = 0; i < 5; i++) send(1'b1, 7'h00, 4'(i + 1), 4'h0);
    wait_idle(1000);
    check("t3_full", saw_full, 1);
    check("t3_count", core_log.size() - base, 7);
    for (int i = 0; i < 5; i++) check("t3_order", core_log[base+2+i], {1'b0, 4'(i + 1), 3'b000});

    // T4: flush while byte1 of a start is in its high phase, three queued behind it
    base = core_log.size();
    send(1'b0, 7'h55, 4'b1001, 4'h1);
    send(1'b1, 7'h00, 4'b0001, 4'h0);
    send(1'b1, 7'h00, 4'b0010, 4'h0);
    send(1'b1, 7'h00, 4'b0100, 4'h0);
    repeat (4) @(negedge clk);
    check("t4_wrn_hi", wrn, 1);
    check("t4_level", level, 3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("t4_flushed", level, 0);
    wait_idle(400);
    check("t4_count", core_log.size() - base, 2);
    check("t4_b2", core_log[base+1], 8'h91);

    // T5: reset during byte2 low phase
    send(1'b0, 7'h33, 4'b1100, 4'h2);
    send(1'b1, 7'h00, 4'b1111, 4'h0);
    repeat (21) @(negedge clk);
    check("t5_b2_low", wrn, 0);
    rst_n = 1'b0;
    #1;
    check("t5_wrn", wrn, 1);
    check("t5_dout", dout, 8'h00);
    check("t5_level", level, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = core_log.size();
    send(1'b0, 7'h7f, 4'hf, 4'h0);
    wait_idle(400);
    check("t5_count", core_log.size() - base, 2);
    check("t5_b1", core_log[base], 8'hff);
    check("t5_b2", core_log[base+1], 8'hf0);

    // T6: random pushes and flushes
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 7'($urandom),
            4'($urandom), 4'($urandom));
      flush = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 7'h0, 4'h0, 4'h0);
    flush = 1'b0;
    wait_idle(2000);
    check("t6_drained", pending.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
